// File: rtl/memmu_reader_pkg.sv
// Shared definitions for the MemMU point-cloud read path.
// Payload field layout, BRAM address map, FSM states, FIFO entry type.
package memmu_reader_pkg;

    localparam int ID_W   = 19;
    localparam int DATA_W = 64;

    // Payload layout, identical to the write-side packer.
    localparam int DIST0_LSB = 0;
    localparam int REFL0_LSB = 16;
    localparam int DIST1_LSB = 24;
    localparam int REFL1_LSB = 40;
    localparam int LABEL_LSB = 48;
    localparam int DIST_W    = 16;
    localparam int REFL_W    = 8;
    localparam int LABEL_W   = 8;

    // BRAM address fields.
    localparam int BRAM_ID_LSB   = 0;
    localparam int BRAM_PCID_LSB = 19;
    localparam int BRAM_OFF_LSB  = 22;

    typedef enum logic {
        IDLE,
        ISSUE
    } rdState_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } rdEntry_t;

    function automatic logic [31:0] bramAddr(
        input logic [9:0]      off,
        input logic [2:0]      pcid,
        input logic [ID_W-1:0] id
    );
        return {off, pcid, id};
    endfunction

endpackage

// File: rtl/memmu_point_reader_if.sv
// Handshake bundle between the point reader, ExMU, MonU and memory.
// slave = reader side, master = environment side.
interface memmu_point_reader_if;

    logic [31:0] i_MonU_MemMU_parameter;
    logic        i_ExMU_readRequest;
    logic [18:0] i_ExMU_pointReadID;
    logic        o_MemMU_R_requestReady;
    logic [31:0] o_MemMU_R_readAddress;
    logic        o_MemMU_R_readValid;
    logic        i_MEM_readReady;
    logic        i_MEM_readDataValid;
    logic [63:0] i_MEM_readData;
    logic        o_MemMU_R_pointValid;
    logic        i_ExMU_pointReady;
    logic [18:0] o_MemMU_R_pointID;
    logic [15:0] o_MemMU_R_distR0;
    logic [7:0]  o_MemMU_R_reflR0;
    logic [15:0] o_MemMU_R_distR1;
    logic [7:0]  o_MemMU_R_reflR1;
    logic [7:0]  o_MemMU_R_label;
    logic        o_MemMU_R_error;

    modport slave (
        input  i_MonU_MemMU_parameter,
        input  i_ExMU_readRequest,
        input  i_ExMU_pointReadID,
        output o_MemMU_R_requestReady,
        output o_MemMU_R_readAddress,
        output o_MemMU_R_readValid,
        input  i_MEM_readReady,
        input  i_MEM_readDataValid,
        input  i_MEM_readData,
        output o_MemMU_R_pointValid,
        input  i_ExMU_pointReady,
        output o_MemMU_R_pointID,
        output o_MemMU_R_distR0,
        output o_MemMU_R_reflR0,
        output o_MemMU_R_distR1,
        output o_MemMU_R_reflR1,
        output o_MemMU_R_label,
        output o_MemMU_R_error
    );

    modport master (
        output i_MonU_MemMU_parameter,
        output i_ExMU_readRequest,
        output i_ExMU_pointReadID,
        input  o_MemMU_R_requestReady,
        input  o_MemMU_R_readAddress,
        input  o_MemMU_R_readValid,
        output i_MEM_readReady,
        output i_MEM_readDataValid,
        output i_MEM_readData,
        input  o_MemMU_R_pointValid,
        output i_ExMU_pointReady,
        input  o_MemMU_R_pointID,
        input  o_MemMU_R_distR0,
        input  o_MemMU_R_reflR0,
        input  o_MemMU_R_distR1,
        input  o_MemMU_R_reflR1,
        input  o_MemMU_R_label,
        input  o_MemMU_R_error
    );

endinterface

// File: rtl/memmu_sync_fifo.sv
// Show-ahead synchronous FIFO with full/empty flags.
// Ports: clk, rst, push/pushData, pop/popData, full, empty.
module memmu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      count;
    logic             doPush;
    logic             doPop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign popData = mem[rdPtr];
    assign doPop   = pop & ~empty;
    // A pop frees the head slot this cycle, so a full FIFO still takes a push.
    assign doPush  = push & (~full | doPop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (doPush) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
        end
    end

endmodule

// File: rtl/memmu_point_reader.sv
// MemMU point reader: ExMU read requests -> memory reads -> unpacked points.
// Ports: clk, sync active-high rst, bus (requests, memory, responses, error).
module memmu_point_reader
    import memmu_reader_pkg::*;
#(
    parameter logic [31:0] OFFSET        = 32'h0,
    parameter logic        BRAM_DDR      = 1'b1,
    parameter logic [2:0]  POINTCLOUD_ID = 3'd0,
    parameter int          DEPTH         = 4
) (
    input logic                 i_SYSTEM_clk,
    input logic                 i_SYSTEM_rst,
    memmu_point_reader_if.slave bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    rdState_t        state;
    rdState_t        nextState;
    logic            reqReady;
    logic            accept;
    logic            respFire;
    logic [CW-1:0]   credit;
    logic [31:0]     ddrAddr;
    logic [31:0]     bramA;
    logic [31:0]     addrNext;
    logic [31:0]     readAddr;
    logic [ID_W-1:0] idHead;
    logic            idFull;
    logic            idEmpty;
    logic            retPush;
    rdEntry_t        dataIn;
    rdEntry_t        dataHead;
    logic            dataFull;
    logic            dataEmpty;
    logic            error;
    logic            unusedBits;

    always_ff @(posedge i_SYSTEM_clk) begin
        if (i_SYSTEM_rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        reqReady  = 1'b0;
        unique case (state)
            IDLE: begin
                reqReady = (credit < CW'(DEPTH));
                if (bus.i_ExMU_readRequest && reqReady) begin
                    nextState = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.i_MEM_readReady) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    assign accept   = bus.i_ExMU_readRequest & reqReady;
    assign respFire = ~dataEmpty & bus.i_ExMU_pointReady;

    assign ddrAddr = bus.i_MonU_MemMU_parameter
                   + {10'd0, bus.i_ExMU_pointReadID, 3'b000};
    assign bramA   = bramAddr(OFFSET[31:BRAM_OFF_LSB], POINTCLOUD_ID,
                              bus.i_ExMU_pointReadID);
    assign addrNext = BRAM_DDR ? ddrAddr : bramA;

    always_ff @(posedge i_SYSTEM_clk) begin
        if (i_SYSTEM_rst) begin
            readAddr <= '0;
        end else if (accept) begin
            readAddr <= addrNext;
        end
    end

    // Credit covers issued reads plus buffered points, so the data FIFO
    // can never overflow on a non-stallable memory return.
    always_ff @(posedge i_SYSTEM_clk) begin
        if (i_SYSTEM_rst) begin
            credit <= '0;
        end else begin
            unique case ({accept, respFire})
                2'b10:   credit <= credit + CW'(1);
                2'b01:   credit <= credit - CW'(1);
                default: credit <= credit;
            endcase
        end
    end

    assign retPush = bus.i_MEM_readDataValid & ~idEmpty;

    always_ff @(posedge i_SYSTEM_clk) begin
        if (i_SYSTEM_rst) begin
            error <= 1'b0;
        end else if (bus.i_MEM_readDataValid && idEmpty) begin
            error <= 1'b1;
        end
    end

    memmu_sync_fifo #(
        .WIDTH (ID_W),
        .DEPTH (DEPTH)
    ) u_idFifo (
        .clk      (i_SYSTEM_clk),
        .rst      (i_SYSTEM_rst),
        .push     (accept),
        .pushData (bus.i_ExMU_pointReadID),
        .pop      (retPush),
        .popData  (idHead),
        .full     (idFull),
        .empty    (idEmpty)
    );

    assign dataIn.id   = idHead;
    assign dataIn.data = bus.i_MEM_readData;

    memmu_sync_fifo #(
        .WIDTH ($bits(rdEntry_t)),
        .DEPTH (DEPTH)
    ) u_dataFifo (
        .clk      (i_SYSTEM_clk),
        .rst      (i_SYSTEM_rst),
        .push     (retPush),
        .pushData (dataIn),
        .pop      (respFire),
        .popData  (dataHead),
        .full     (dataFull),
        .empty    (dataEmpty)
    );

    // Reserved payload byte and flags that credit makes redundant.
    assign unusedBits = ^{dataHead.data[DATA_W-1:LABEL_LSB+LABEL_W],
                          idFull, dataFull};

    assign bus.o_MemMU_R_requestReady = reqReady;
    assign bus.o_MemMU_R_readAddress  = readAddr;
    assign bus.o_MemMU_R_readValid    = (state == ISSUE);
    assign bus.o_MemMU_R_pointValid   = ~dataEmpty;
    assign bus.o_MemMU_R_pointID      = dataHead.id;
    assign bus.o_MemMU_R_distR0 = dataHead.data[DIST0_LSB +: DIST_W];
    assign bus.o_MemMU_R_reflR0 = dataHead.data[REFL0_LSB +: REFL_W];
    assign bus.o_MemMU_R_distR1 = dataHead.data[DIST1_LSB +: DIST_W];
    assign bus.o_MemMU_R_reflR1 = dataHead.data[REFL1_LSB +: REFL_W];
    assign bus.o_MemMU_R_label  = dataHead.data[LABEL_LSB +: LABEL_W];
    assign bus.o_MemMU_R_error  = error;

endmodule

// File: tb/tb_memmu_point_reader.sv
// Self-checking bench for memmu_point_reader (DDR and BRAM instances).
// Memory model with fixed latency and an in-order point scoreboard.
module tb_memmu_point_reader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    memmu_point_reader_if ifD();
    memmu_point_reader_if ifB();

    memmu_point_reader #(
        .OFFSET        (32'h0),
        .BRAM_DDR      (1'b1),
        .POINTCLOUD_ID (3'd0),
        .DEPTH         (4)
    ) dutD (
        .i_SYSTEM_clk (clk),
        .i_SYSTEM_rst (rst),
        .bus          (ifD)
    );

    memmu_point_reader #(
        .OFFSET        (32'h4000_0000),
        .BRAM_DDR      (1'b0),
        .POINTCLOUD_ID (3'd2),
        .DEPTH         (4)
    ) dutB (
        .i_SYSTEM_clk (clk),
        .i_SYSTEM_rst (rst),
        .bus          (ifB)
    );

    typedef struct {
        logic [18:0] id;
        logic [63:0] word;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] base;
        logic [18:0] id;
        logic [31:0] addr;
    } ddrVec_t;

    typedef struct {
        logic [18:0] id;
        logic [31:0] addr;
    } bramVec_t;

    exp_t  expQ[$];
    pend_t pendQ[$];
    int    nChk = 0;
    int    nFail = 0;
    int    cyc = 0;
    bit    memAuto = 1'b0;
    logic  respDv = 1'b0;
    logic  manDv = 1'b0;
    logic [63:0] respData = '0;
    logic [63:0] manData = '0;

    assign ifD.i_MEM_readDataValid = respDv | manDv;
    assign ifD.i_MEM_readData      = manDv ? manData : respData;

    function automatic logic [63:0] memWord(input logic [31:0] a);
        if (a == 32'h1000_0028) begin
            return 64'h00AB_1234_5678_9ABC;
        end
        return {8'hC3, a[15:0], a ^ 32'h5A5A_5A5A, 8'h11};
    endfunction

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        nChk++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory model and scoreboard, evaluated mid-cycle.
    task automatic service();
        exp_t e;
        respDv = 1'b0;
        if (memAuto && pendQ.size() > 0 && pendQ[0].due <= cyc) begin
            respDv   = 1'b1;
            respData = memWord(pendQ[0].addr);
            void'(pendQ.pop_front());
        end
        if (memAuto && ifD.o_MemMU_R_readValid && ifD.i_MEM_readReady) begin
            pendQ.push_back('{ifD.o_MemMU_R_readAddress, cyc + 2});
        end
        if (ifD.o_MemMU_R_pointValid && ifD.i_ExMU_pointReady) begin
            if (expQ.size() == 0) begin
                check("unexpected point", 1, 0);
            end else begin
                e = expQ.pop_front();
                check("pointID", ifD.o_MemMU_R_pointID, e.id);
                check("distR0", ifD.o_MemMU_R_distR0, e.word[15:0]);
                check("reflR0", ifD.o_MemMU_R_reflR0, e.word[23:16]);
                check("distR1", ifD.o_MemMU_R_distR1, e.word[39:24]);
                check("reflR1", ifD.o_MemMU_R_reflR1, e.word[47:40]);
                check("label", ifD.o_MemMU_R_label, e.word[55:48]);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        service();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic sendReq(input logic [18:0] id, input logic [31:0] addr);
        int n = 0;
        ifD.i_ExMU_readRequest = 1'b1;
        ifD.i_ExMU_pointReadID = id;
        while (!ifD.o_MemMU_R_requestReady && n < 50) begin
            step();
            n++;
        end
        if (!ifD.o_MemMU_R_requestReady) begin
            check("request accept timeout", 0, 1);
        end else begin
            expQ.push_back('{id, memWord(addr)});
            step();
        end
        ifD.i_ExMU_readRequest = 1'b0;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((expQ.size() > 0 || pendQ.size() > 0) && n < bound) begin
            step();
            n++;
        end
        check("drain outstanding", expQ.size(), 0);
    endtask

    ddrVec_t  ddrTab[5];
    bramVec_t bramTab[3];

    initial begin
        int acc;

        ddrTab[0] = '{32'h1000_0000, 19'd1,       32'h1000_0008};
        ddrTab[1] = '{32'hFFFF_FFF8, 19'd2,       32'h0000_0008};
        ddrTab[2] = '{32'h0000_0000, 19'h7FFFF,   32'h003F_FFF8};
        ddrTab[3] = '{32'h8000_0004, 19'h40000,   32'h8020_0004};
        ddrTab[4] = '{32'hFFFF_FFFF, 19'h7FFFF,   32'h003F_FFF7};
        bramTab[0] = '{19'h12345, 32'h4011_2345};
        bramTab[1] = '{19'h00000, 32'h4010_0000};
        bramTab[2] = '{19'h7FFFF, 32'h4017_FFFF};

        rst = 1'b1;
        ifD.i_MonU_MemMU_parameter = 32'h1000_0000;
        ifD.i_ExMU_readRequest     = 1'b0;
        ifD.i_ExMU_pointReadID     = '0;
        ifD.i_MEM_readReady        = 1'b1;
        ifD.i_ExMU_pointReady      = 1'b0;
        ifB.i_MonU_MemMU_parameter = '0;
        ifB.i_ExMU_readRequest     = 1'b0;
        ifB.i_ExMU_pointReadID     = '0;
        ifB.i_MEM_readReady        = 1'b1;
        ifB.i_MEM_readDataValid    = 1'b0;
        ifB.i_MEM_readData         = '0;
        ifB.i_ExMU_pointReady      = 1'b1;
        step();
        step();
        rst = 1'b0;

        check("reset requestReady", ifD.o_MemMU_R_requestReady, 1);
        check("reset readValid", ifD.o_MemMU_R_readValid, 0);
        check("reset readAddress", ifD.o_MemMU_R_readAddress, 0);
        check("reset pointValid", ifD.o_MemMU_R_pointValid, 0);
        check("reset pointID", ifD.o_MemMU_R_pointID, 0);
        check("reset error", ifD.o_MemMU_R_error, 0);

        // DDR ID 5 with a hand-driven memory return.
        sendReq(19'd5, 32'h1000_0028);
        check("id5 readValid T+1", ifD.o_MemMU_R_readValid, 1);
        check("id5 address", ifD.o_MemMU_R_readAddress, 32'h1000_0028);
        step();
        check("id5 readValid done", ifD.o_MemMU_R_readValid, 0);
        check("id5 pointValid early", ifD.o_MemMU_R_pointValid, 0);
        manDv   = 1'b1;
        manData = 64'h00AB_1234_5678_9ABC;
        step();
        manDv = 1'b0;
        check("id5 pointValid D+1", ifD.o_MemMU_R_pointValid, 1);
        check("id5 label", ifD.o_MemMU_R_label, 8'hAB);
        ifD.i_ExMU_pointReady = 1'b1;
        step();
        check("id5 pointValid popped", ifD.o_MemMU_R_pointValid, 0);

        // DDR address table, including modulo-2^32 wrap.
        memAuto = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ifD.i_MonU_MemMU_parameter = ddrTab[i].base;
            sendReq(ddrTab[i].id, ddrTab[i].addr);
            ifD.i_MonU_MemMU_parameter = ~ddrTab[i].base;
            check("ddr readValid", ifD.o_MemMU_R_readValid, 1);
            check("ddr address", ifD.o_MemMU_R_readAddress, ddrTab[i].addr);
            drain(50);
        end
        ifD.i_MonU_MemMU_parameter = 32'h1000_0000;

        // BRAM address table.
        for (int i = 0; i < 3; i++) begin
            ifB.i_ExMU_readRequest = 1'b1;
            ifB.i_ExMU_pointReadID = bramTab[i].id;
            check("bram requestReady", ifB.o_MemMU_R_requestReady, 1);
            step();
            ifB.i_ExMU_readRequest = 1'b0;
            check("bram readValid", ifB.o_MemMU_R_readValid, 1);
            check("bram address", ifB.o_MemMU_R_readAddress, bramTab[i].addr);
            step();
        end

        // Memory address backpressure.
        ifD.i_MEM_readReady = 1'b0;
        sendReq(19'd7, 32'h1000_0038);
        ifD.i_ExMU_readRequest = 1'b1;
        ifD.i_ExMU_pointReadID = 19'd8;
        for (int i = 0; i < 5; i++) begin
            check("stall readValid", ifD.o_MemMU_R_readValid, 1);
            check("stall address", ifD.o_MemMU_R_readAddress, 32'h1000_0038);
            check("stall requestReady", ifD.o_MemMU_R_requestReady, 0);
            step();
        end
        ifD.i_ExMU_readRequest = 1'b0;
        ifD.i_MEM_readReady    = 1'b1;
        step();
        drain(50);

        // Credit limit with responses stalled.
        ifD.i_ExMU_pointReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sendReq(19'(i), 32'h1000_0000 + 32'(i * 8));
        end
        ifD.i_ExMU_readRequest = 1'b1;
        ifD.i_ExMU_pointReadID = 19'd4;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            if (ifD.o_MemMU_R_requestReady) acc++;
            step();
        end
        ifD.i_ExMU_readRequest = 1'b0;
        check("credit extra accepts", acc, 0);
        check("credit requestReady", ifD.o_MemMU_R_requestReady, 0);
        check("credit buffered", ifD.o_MemMU_R_pointValid, 1);
        ifD.i_ExMU_pointReady = 1'b1;
        sendReq(19'd4, 32'h1000_0020);
        sendReq(19'd5, 32'h1000_0028);
        drain(100);

        // Memory data with nothing outstanding.
        check("pre error", ifD.o_MemMU_R_error, 0);
        manDv   = 1'b1;
        manData = 64'hDEAD_BEEF_0123_4567;
        step();
        manDv = 1'b0;
        check("error set", ifD.o_MemMU_R_error, 1);
        check("error no point", ifD.o_MemMU_R_pointValid, 0);
        for (int i = 0; i < 3; i++) step();
        check("error sticky", ifD.o_MemMU_R_error, 1);
        check("error still no point", ifD.o_MemMU_R_pointValid, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("error cleared", ifD.o_MemMU_R_error, 0);

        // Reset with reads in flight.
        ifD.i_ExMU_pointReady = 1'b0;
        sendReq(19'd10, 32'h1000_0050);
        sendReq(19'd11, 32'h1000_0058);
        rst = 1'b1;
        step();
        rst = 1'b0;
        expQ.delete();
        check("mid reset pointValid", ifD.o_MemMU_R_pointValid, 0);
        check("mid reset requestReady", ifD.o_MemMU_R_requestReady, 1);
        check("mid reset readValid", ifD.o_MemMU_R_readValid, 0);
        check("mid reset error", ifD.o_MemMU_R_error, 0);
        for (int i = 0; i < 10 && pendQ.size() > 0; i++) step();
        step();
        check("late data error", ifD.o_MemMU_R_error, 1);
        check("late data no point", ifD.o_MemMU_R_pointValid, 0);

        // Full credit available again after reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sendReq(19'(20 + i), 32'h1000_0000 + 32'((20 + i) * 8));
        end
        for (int i = 0; i < 6; i++) step();
        check("post reset requestReady", ifD.o_MemMU_R_requestReady, 0);
        ifD.i_ExMU_pointReady = 1'b1;
        drain(100);
        check("post reset error", ifD.o_MemMU_R_error, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChk, nFail);
        $finish;
    end

endmodule
